uart_cmd_responder: RTL and testbench
=====================================

# uart_cmd_responder

Host-facing command responder that sits on the far side of the UART from the CPU's buffered serial port. It parses framed command packets arriving as received bytes, performs 16-bit reads and writes on the internal memory bus as a bus initiator, and returns acknowledgement or read data as transmit bytes. The block is used as the debug and loader path into the console's memory space.

## Interface
- `TIMEOUT`, default 50000: inter-byte timeout in CLK cycles; a partial packet is discarded after this many idle cycles.
- `CLK`  in  1  system clock, all logic on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `rxData`  in  8  received byte from UART, valid while `rxReady` is high.
- `rxReady`  in  1  single-cycle pulse, one per received byte.
- `txData`  out  8  byte to transmit, stable from the `txStart` cycle until `txBusy` falls.
- `txStart`  out  1  single-cycle pulse requesting transmission of `txData`.
- `txBusy`  in  1  UART transmitter busy.
- `busAddr`  out  16  bus address.
- `busDataOut`  out  16  bus write data.
- `busWrite`  out  1  single-cycle write strobe.
- `busRead`  out  1  single-cycle read strobe.
- `busDataIn`  in  16  read data, valid in the cycle after `busRead`.
- `active`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Packet formats (multi-byte fields big-endian):
  - Write: 0x57, addrHi, addrLo, dataHi, dataLo. Reply 0x06.
  - Read: 0x52, addrHi, addrLo. Reply dataHi, dataLo.
  - Any other first byte: reply 0x15, no bus access.
- FSM states: IDLE, ARGS, EXEC, RDWAIT, SEND, GUARD.
  - IDLE: on `rxReady`, latch the command. If it is 0x57, load the argument counter with 4. If it is 0x52, load it with 2. Either way go to ARGS. Otherwise queue the 0x15 reply and go to SEND.
  - ARGS: each `rxReady` shifts `rxData` into the address/data shift register and decrements the counter. When the counter reaches 0, go to EXEC.
  - EXEC: one cycle. Assert `busWrite` or `busRead`. A write queues the 0x06 reply and goes to SEND. A read goes to RDWAIT.
  - RDWAIT: one cycle. Capture `busDataIn`, queue two reply bytes (high byte first), go to SEND.
  - SEND: wait for `txBusy` low. Then drive `txData`, pulse `txStart`, and go to GUARD.
  - GUARD: one cycle, so the UART can raise `txBusy`. If bytes remain in the queue, go to SEND; otherwise go to IDLE.
- `busAddr` and `busDataOut` hold their last loaded values between packets. Both strobes are low outside EXEC.
- Timeout: in ARGS, a counter clears on every `rxReady` and increments otherwise. When it reaches `TIMEOUT`, go to IDLE with no reply and no bus access.
- Any `rxReady` received in EXEC, RDWAIT, SEND or GUARD is dropped. The host must wait for the reply before sending the next packet.
- `rxReady` together with the timeout terminal count in the same cycle: the byte wins, and the timeout counter clears.

## Timing
- Reset values: `txData`=0x00, `txStart`=0, `busAddr`=0x0000, `busDataOut`=0x0000, `busWrite`=0, `busRead`=0, `active`=0, state IDLE, timeout counter 0.
- Asserting `RST` mid-packet or mid-reply returns the FSM to IDLE immediately. A byte already handed to the UART completes transmission; the remaining queued reply bytes are lost.
- Write, last byte `rxReady` in cycle N:
  - `busWrite` is high in cycle N+1.
  - `txStart` carrying 0x06 is high in cycle N+2 if `txBusy` is low.
- Read, last byte in cycle N:
  - `busRead` is high in cycle N+1.
  - `busDataIn` is sampled at the end of cycle N+2.
  - `txStart` carrying dataHi is high in cycle N+3 if `txBusy` is low.
- Invalid command byte in cycle N: `txStart` carrying 0x15 is high in cycle N+1 if `txBusy` is low.
- Minimum spacing between `txStart` pulses is 2 cycles, further extended by `txBusy`.
- `active` is registered and follows the state, so it rises the cycle after the first byte.

## Test plan
- Reset: after `RST` releases, check every output against its reset value. Send 0x57 00 10 BE EF -> `busWrite` is high one cycle with `busAddr`=0x0010 and `busDataOut`=0xBEEF, then 0x06 is transmitted.
- Read: send 0x52 12 34, with the bus model returning 0xA55A -> `busRead` pulses with `busAddr`=0x1234, then 0xA5 and 0x5A are transmitted in order, each only after `txBusy` falls.
- Invalid command: send 0x41 -> 0x15 is transmitted, no bus strobe occurs, FSM returns to IDLE.
- Timeout: send 0x57 00 then idle for `TIMEOUT`+2 cycles, then send 0x52 00 01 -> no write occurs, and exactly one read of 0x0001 is performed and replied to.
- Busy and drop: hold `txBusy` high for 500 cycles during a read reply and inject `rxReady` 0x57 while in SEND -> the injected byte is ignored, and the reply bytes go out after `txBusy` falls.
- Mid-packet reset: assert `RST` after 0x57 00 10 BE -> FSM returns to IDLE, and a following complete write packet executes normally.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// UART command responder: parses write/read/invalid command packets from the
// receive byte stream, runs 16-bit bus accesses and queues reply bytes.
module uart_cmd_responder #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  rxData,
  input  logic        rxReady,
  output logic [7:0]  txData,
  output logic        txStart,
  input  logic        txBusy,
  output logic [15:0] busAddr,
  output logic [15:0] busDataOut,
  output logic        busWrite,
  output logic        busRead,
  input  logic [15:0] busDataIn,
  output logic        active
);

  localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] REPLY_ACK = 8'h06;
  localparam logic [7:0] REPLY_NAK = 8'h15;

  typedef enum logic [2:0] {IDLE, ARGS, EXEC, RDWAIT, SEND, GUARD} state_t;

  state_t        state, state_next;
  logic          is_write;
  logic [2:0]    arg_cnt;
  logic [23:0]   shift_reg;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic [7:0]    q_head, q_tail, tx_hold;
  logic [1:0]    q_count;

  assign to_hit = (to_cnt == TW'(TIMEOUT));

  // State register and registered activity flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      active <= (state_next != IDLE);
    end
  end

  // Next-state logic and strobes; txData shows the queue head during the
  // txStart cycle and the held byte afterwards so it stays stable while busy
  always_comb begin
    state_next = state;
    busWrite   = 1'b0;
    busRead    = 1'b0;
    txStart    = 1'b0;
    txData     = tx_hold;
    case (state)
      IDLE: begin
        if (rxReady) begin
          if (rxData == CMD_WRITE || rxData == CMD_READ) state_next = ARGS;
          else                                           state_next = SEND;
        end
      end
      ARGS: begin
        if (rxReady) begin
          if (arg_cnt == 3'd1) state_next = EXEC;
        end else if (to_hit) begin
          state_next = IDLE;
        end
      end
      EXEC: begin
        busWrite   = is_write;
        busRead    = !is_write;
        state_next = is_write ? SEND : RDWAIT;
      end
      RDWAIT: state_next = SEND;
      SEND: begin
        if (!txBusy) begin
          txStart    = 1'b1;
          txData     = q_head;
          state_next = GUARD;
        end
      end
      GUARD: state_next = (q_count != 2'd0) ? SEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: command latch, argument shifting, bus registers, reply queue
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      is_write   <= 1'b0;
      arg_cnt    <= '0;
      shift_reg  <= '0;
      to_cnt     <= '0;
      q_head     <= '0;
      q_tail     <= '0;
      q_count    <= '0;
      tx_hold    <= '0;
      busAddr    <= '0;
      busDataOut <= '0;
    end else begin
      to_cnt <= '0;
      case (state)
        IDLE: begin
          if (rxReady) begin
            is_write <= (rxData == CMD_WRITE);
            arg_cnt  <= (rxData == CMD_WRITE) ? 3'd4 : 3'd2;
            if (rxData != CMD_WRITE && rxData != CMD_READ) begin
              q_head  <= REPLY_NAK;
              q_count <= 2'd1;
            end
          end
        end
        ARGS: begin
          if (rxReady) begin
            shift_reg <= {shift_reg[15:0], rxData};
            arg_cnt   <= arg_cnt - 3'd1;
            // Last byte: the earlier bytes are still in the shift register
            if (arg_cnt == 3'd1) begin
              if (is_write) begin
                busAddr    <= shift_reg[23:8];
                busDataOut <= {shift_reg[7:0], rxData};
              end else begin
                busAddr    <= {shift_reg[7:0], rxData};
              end
            end
          end else if (!to_hit) begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        EXEC: begin
          if (is_write) begin
            q_head  <= REPLY_ACK;
            q_count <= 2'd1;
          end
        end
        RDWAIT: begin
          q_head  <= busDataIn[15:8];
          q_tail  <= busDataIn[7:0];
          q_count <= 2'd2;
        end
        SEND: begin
          if (txStart) begin
            tx_hold <= q_head;
            q_head  <= q_tail;
            q_count <= q_count - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: directed latency/boundary cases followed by a
// random byte stream checked against a packet-level reference model.
module tb_uart_cmd_responder;

  localparam int unsigned TO = 40;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  rxData;
  logic        rxReady;
  logic [7:0]  txData;
  logic        txStart;
  logic        txBusy;
  logic [15:0] busAddr, busDataOut, busDataIn;
  logic        busWrite, busRead, active;

  always #5 CLK = ~CLK;

  uart_cmd_responder #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .rxData(rxData), .rxReady(rxReady),
    .txData(txData), .txStart(txStart), .txBusy(txBusy),
    .busAddr(busAddr), .busDataOut(busDataOut), .busWrite(busWrite),
    .busRead(busRead), .busDataIn(busDataIn), .active(active)
  );

  typedef struct packed {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
  } op_t;

  int total = 0;
  int bad   = 0;
  op_t        got_ops[$], exp_ops[$];
  logic [7:0] got_tx[$], exp_tx[$];
  logic [15:0] bus_mem [65536];
  logic [15:0] ref_mem [65536];
  bit force_busy = 1'b0;

  // reference model: packet-level parse state
  int         m_need = 0;
  int         m_n = 0;
  logic [7:0] m_cmd;
  logic [7:0] m_args [4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // UART transmitter model: records bytes, raises txBusy for a random time
  initial begin
    int busy_cnt;
    bit seen;
    logic [7:0] last;
    busy_cnt = 0;
    last = 8'h00;
    txBusy = 1'b0;
    forever begin
      @(negedge CLK);
      seen = 1'b0;
      if (busy_cnt > 0) check_eq("tx_stable", txData, last);
      if (txStart) begin
        check_eq("start_while_busy", txBusy, 0);
        got_tx.push_back(txData);
        last = txData;
        seen = 1'b1;
      end
      @(posedge CLK);
      #1;
      if (seen) busy_cnt = $urandom_range(0, 5);
      else if (busy_cnt > 0) busy_cnt--;
      txBusy = force_busy || (busy_cnt != 0);
    end
  end

  // Bus target model: memory, read data valid only in the cycle after busRead
  initial begin
    int hold;
    op_t o;
    hold = 0;
    busDataIn = '0;
    forever begin
      @(negedge CLK);
      if (busWrite) begin
        check_eq("rd_with_wr", busRead, 0);
        o.w = 1'b1; o.a = busAddr; o.d = busDataOut;
        got_ops.push_back(o);
        bus_mem[busAddr] = busDataOut;
      end
      if (busRead) begin
        o.w = 1'b0; o.a = busAddr; o.d = 16'h0;
        got_ops.push_back(o);
        busDataIn = bus_mem[busAddr];
        hold = 1;
      end else if (hold != 0) begin
        hold = 0;
      end else begin
        busDataIn = 16'($urandom);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic model_byte(input logic [7:0] b, input int gap, output bit done);
    op_t o;
    done = 1'b0;
    if (m_need != 0 && gap > int'(TO)) m_need = 0;
    if (m_need == 0) begin
      m_cmd = b;
      m_n = 0;
      if (b == 8'h57) m_need = 4;
      else if (b == 8'h52) m_need = 2;
      else begin
        exp_tx.push_back(8'h15);
        done = 1'b1;
      end
    end else begin
      m_args[m_n] = b;
      m_n++;
      m_need--;
      if (m_need == 0) begin
        o.a = {m_args[0], m_args[1]};
        if (m_cmd == 8'h57) begin
          o.w = 1'b1;
          o.d = {m_args[2], m_args[3]};
          ref_mem[o.a] = o.d;
          exp_tx.push_back(8'h06);
        end else begin
          o.w = 1'b0;
          o.d = 16'h0;
          exp_tx.push_back(ref_mem[o.a][15:8]);
          exp_tx.push_back(ref_mem[o.a][7:0]);
        end
        exp_ops.push_back(o);
        done = 1'b1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge CLK);
      #1;
    end
    rxData = b;
    rxReady = 1'b1;
    @(posedge CLK);
    #1;
    rxReady = 1'b0;
    rxData = 8'($urandom);
  endtask

  task automatic feed(input logic [7:0] b, input int gap, output bit done);
    send_byte(b, gap);
    model_byte(b, gap, done);
  endtask

  task automatic finish_check(input string tag);
    int run;
    int n;
    run = 0;
    n = 0;
    while (run < 3 && n < 3000) begin
      @(negedge CLK);
      n++;
      if (!active && !txBusy) run++;
      else run = 0;
    end
    check_eq({tag, "_idle"}, run, 3);
    @(posedge CLK);
    #1;
    check_eq({tag, "_nops"}, got_ops.size(), exp_ops.size());
    for (int i = 0; i < exp_ops.size() && i < got_ops.size(); i++)
      check_eq({tag, "_op"}, got_ops[i], exp_ops[i]);
    check_eq({tag, "_ntx"}, got_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
      check_eq({tag, "_tx"}, got_tx[i], exp_tx[i]);
    got_ops.delete();
    exp_ops.delete();
    got_tx.delete();
    exp_tx.delete();
  endtask

  initial begin
    bit done;
    int r;
    int gap;
    logic [7:0] b;
    for (int i = 0; i < 65536; i++) begin
      bus_mem[i] = 16'(i * 37) ^ 16'h5A3C;
      ref_mem[i] = bus_mem[i];
    end
    RST = 1'b1;
    rxData = 8'h00;
    rxReady = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_eq("rst_txData", txData, 8'h00);
    check_eq("rst_txStart", txStart, 0);
    check_eq("rst_busAddr", busAddr, 16'h0000);
    check_eq("rst_busDataOut", busDataOut, 16'h0000);
    check_eq("rst_busWrite", busWrite, 0);
    check_eq("rst_busRead", busRead, 0);
    check_eq("rst_active", active, 0);
    @(posedge CLK);
    #1;

    // write with cycle-exact latency
    feed(8'h57, 0, done);
    feed(8'h00, 0, done);
    feed(8'h10, 0, done);
    feed(8'hBE, 0, done);
    feed(8'hEF, 0, done);
    @(negedge CLK);
    check_eq("wr_strobe", busWrite, 1);
    check_eq("wr_addr", busAddr, 16'h0010);
    check_eq("wr_data", busDataOut, 16'hBEEF);
    check_eq("wr_no_read", busRead, 0);
    @(negedge CLK);
    check_eq("wr_strobe_len", busWrite, 0);
    check_eq("wr_ack_start", txStart, 1);
    check_eq("wr_ack_byte", txData, 8'h06);
    finish_check("wr");

    // read with cycle-exact latency
    bus_mem[16'h1234] = 16'hA55A;
    ref_mem[16'h1234] = 16'hA55A;
    feed(8'h52, 0, done);
    feed(8'h12, 0, done);
    feed(8'h34, 0, done);
    @(negedge CLK);
    check_eq("rd_strobe", busRead, 1);
    check_eq("rd_addr", busAddr, 16'h1234);
    @(negedge CLK);
    check_eq("rd_strobe_len", busRead, 0);
    check_eq("rd_start_early", txStart, 0);
    @(negedge CLK);
    check_eq("rd_hi_start", txStart, 1);
    check_eq("rd_hi_byte", txData, 8'hA5);
    finish_check("rd");

    // invalid command
    feed(8'h41, 0, done);
    @(negedge CLK);
    check_eq("inv_start", txStart, 1);
    check_eq("inv_byte", txData, 8'h15);
    finish_check("inv");

    // timeout abandons partial write, then a read executes
    feed(8'h57, 0, done);
    feed(8'h00, 0, done);
    feed(8'h52, TO + 2, done);
    feed(8'h00, 0, done);
    feed(8'h01, 0, done);
    finish_check("to");

    // byte arriving on the terminal count is accepted
    feed(8'h52, 0, done);
    feed(8'h00, TO, done);
    feed(8'h07, TO, done);
    finish_check("to_edge_ok");
    // one cycle later it is too late and becomes a new command
    feed(8'h52, 0, done);
    feed(8'h00, TO + 1, done);
    finish_check("to_edge_late");

    // txBusy held during a read reply, with a byte injected while in SEND
    force_busy = 1'b1;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    feed(8'h52, 0, done);
    feed(8'h00, 0, done);
    feed(8'h20, 0, done);
    repeat (10) begin
      @(posedge CLK);
      #1;
    end
    send_byte(8'h57, 0);
    repeat (480) begin
      @(posedge CLK);
      #1;
    end
    check_eq("busy_no_tx", got_tx.size(), 0);
    check_eq("busy_active", active, 1);
    force_busy = 1'b0;
    finish_check("busy");
    feed(8'h57, 0, done);
    feed(8'h00, 0, done);
    feed(8'h21, 0, done);
    feed(8'h12, 0, done);
    feed(8'h34, 0, done);
    finish_check("after_drop");

    // reset in the middle of a write packet
    feed(8'h57, 0, done);
    feed(8'h00, 0, done);
    feed(8'h10, 0, done);
    feed(8'hBE, 0, done);
    RST = 1'b1;
    m_need = 0;
    @(negedge CLK);
    check_eq("mid_rst_active", active, 0);
    check_eq("mid_rst_addr", busAddr, 16'h0000);
    check_eq("mid_rst_data", busDataOut, 16'h0000);
    @(posedge CLK);
    #1 RST = 1'b0;
    feed(8'h57, 0, done);
    feed(8'h00, 0, done);
    feed(8'h30, 0, done);
    feed(8'hCA, 0, done);
    feed(8'hFE, 0, done);
    finish_check("post_rst");

    // random byte stream with gaps around the timeout boundary
    for (int k = 0; k < 400; k++) begin
      if (m_need == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4) b = 8'h57;
        else if (r < 8) b = 8'h52;
        else b = 8'($urandom);
        gap = $urandom_range(0, 3);
      end else begin
        b = (m_n < 2) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        r = $urandom_range(0, 9);
        if (r < 6) gap = $urandom_range(0, 3);
        else if (r == 6) gap = TO;
        else if (r == 7) gap = TO + 1;
        else if (r == 8) gap = TO - 1;
        else gap = TO + $urandom_range(2, 10);
      end
      feed(b, gap, done);
      if (done) finish_check("rnd");
    end
    if (m_need != 0) begin
      repeat (TO + 5) begin
        @(posedge CLK);
        #1;
      end
      m_need = 0;
    end
    finish_check("rnd_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
